// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter for a shared combinational ALU
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_sel,
  input  logic             flush,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [3:0]       op_sel_q, op_sel_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic v0, v1, pick1, accept, cancel;

  // A flush blocks requester 0 from being granted in the same cycle.
  assign v0     = req0_valid & ~flush;
  assign v1     = req1_valid;
  assign accept = (state_q == IDLE) & ~rst & (v0 | v1);
  assign cancel = flush & ~owner_q;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // last_q holds the id of the most recent grant; the other requester wins a tie.
  assign pick1  = v1 & (~v0 | ~last_q);
  assign last_d = accept ? pick1 : last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign pick1 = v1 & ~v0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = cancel ? IDLE : RESP;
      RESP:    if (cancel || rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = accept & ~pick1;
    req1_ready = accept & pick1;
    alu_a      = '0;
    alu_b      = '0;
    alu_sel    = 4'd0;
    if (state_q == EXEC) begin
      alu_a   = op_a_q;
      alu_b   = op_b_q;
      alu_sel = op_sel_q;
    end
    // A response cancelled by flush must never be seen as a completed handshake.
    rsp_valid = (state_q == RESP) & ~cancel;
    rsp_id    = owner_q;
    rsp_data  = rsp_data_q;
  end

  always_comb begin
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_sel_d   = op_sel_q;
    owner_d    = owner_q;
    rsp_data_d = rsp_data_q;
    if (accept) begin
      op_a_d   = pick1 ? req1_a   : req0_a;
      op_b_d   = pick1 ? req1_b   : req0_b;
      op_sel_d = pick1 ? req1_sel : req0_sel;
      owner_d  = pick1;
    end
    if (state_q == EXEC) begin
      rsp_data_d = alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_sel_q   <= 4'd0;
      owner_q    <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_sel_q   <= op_sel_d;
      owner_q    <= owner_d;
      rsp_data_q <= rsp_data_d;
    end
  end

endmodule
